// File: rtl/attn_stream_loader.sv
// attn_stream_loader
//   Stream-side driver for the transformer attention unit. A serial word
//   stream delivers one token vector x and, unless the load is x-only, the
//   Q/K/V/O weight matrices. The words are assembled into the attention
//   unit's flattened operand buses. A one-cycle start strobe is issued, the
//   returned result vector is captured, and it is streamed back out.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   s_valid/s_ready       input stream handshake
//   s_data, s_last        input word and end-of-load marker
//   reuse_w               sampled on the first beat: 1 = x-only load
//   x_flat                operand vector, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wq/wk/wv/wo_flat      weights, (i,j) at [(i*EMBED_DIM+j)*DATA_WIDTH +: DATA_WIDTH]
//   attn_start            one-cycle start strobe to the attention unit
//   attn_done, attn_y     attention unit result valid and result vector
//   m_valid/m_ready       output stream handshake
//   m_data, m_last        output word and end-of-vector marker
//   busy                  high in every state except IDLE
//   err                   sticky framing error, cleared only by rst
module attn_stream_loader #(
    parameter int EMBED_DIM  = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    input  logic                                          s_last,
    input  logic                                          reuse_w,
    output logic [EMBED_DIM*DATA_WIDTH-1:0]               x_flat,
    output logic [EMBED_DIM*EMBED_DIM*DATA_WIDTH-1:0]     wq_flat,
    output logic [EMBED_DIM*EMBED_DIM*DATA_WIDTH-1:0]     wk_flat,
    output logic [EMBED_DIM*EMBED_DIM*DATA_WIDTH-1:0]     wv_flat,
    output logic [EMBED_DIM*EMBED_DIM*DATA_WIDTH-1:0]     wo_flat,
    output logic                                          attn_start,
    input  logic                                          attn_done,
    input  logic [EMBED_DIM*DATA_WIDTH-1:0]               attn_y,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_WIDTH-1:0]                         m_data,
    output logic                                          m_last,
    output logic                                          busy,
    output logic                                          err
);

    localparam int MSZ = EMBED_DIM * EMBED_DIM;
    localparam int NW  = 4 * MSZ;
    localparam int CW  = $clog2(NW);
    localparam int KW  = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, FIRE, WAIT, SEND} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic            xonly_q, xonly_d;
    logic            w_loaded_q, w_loaded_d;
    logic            err_q, err_d;

    logic signed [DATA_WIDTH-1:0] x_q [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] w_q [NW];
    logic signed [DATA_WIDTH-1:0] y_q [EMBED_DIM];

    logic            x_we, w_we, y_we;
    logic [KW-1:0]   x_idx;
    logic            eff_xonly;
    logic            loading;

    // A reuse request only counts as x-only when a complete weight set is held.
    assign eff_xonly = reuse_w & w_loaded_q;
    assign loading   = (state_q == IDLE) || (state_q == LOAD_X) || (state_q == LOAD_W);

    // s_ready is forced low while reset is asserted so no beat is offered.
    assign s_ready    = loading & ~rst;
    assign busy       = (state_q != IDLE);
    assign attn_start = (state_q == FIRE);
    assign m_valid    = (state_q == SEND);
    assign m_last     = (state_q == SEND) && (k_q == KW'(EMBED_DIM - 1));
    assign m_data     = y_q[k_q];
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        xonly_d    = xonly_q;
        w_loaded_d = w_loaded_q;
        err_d      = err_q;
        x_we       = 1'b0;
        x_idx      = '0;
        w_we       = 1'b0;
        y_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    x_we    = 1'b1;
                    xonly_d = eff_xonly;
                    cnt_d   = CW'(1);
                    if (reuse_w && !w_loaded_q) begin
                        err_d = 1'b1;
                    end
                    if ((EMBED_DIM == 1) && eff_xonly) begin
                        // Single-word x-only load: this beat is the final word.
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                        state_d = FIRE;
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (EMBED_DIM == 1) begin
                        cnt_d   = '0;
                        state_d = LOAD_W;
                    end else begin
                        state_d = LOAD_X;
                    end
                end
            end

            LOAD_X: begin
                if (s_valid) begin
                    x_we  = 1'b1;
                    x_idx = cnt_q[KW-1:0];
                    if (cnt_q == CW'(EMBED_DIM - 1)) begin
                        if (xonly_q) begin
                            if (!s_last) begin
                                err_d = 1'b1;
                            end
                            state_d = FIRE;
                        end else if (s_last) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = '0;
                            state_d = LOAD_W;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // The counter runs over all four matrices in stream order, so it
            // addresses the concatenated weight storage directly.
            LOAD_W: begin
                if (s_valid) begin
                    w_we = 1'b1;
                    if (cnt_q == CW'(NW - 1)) begin
                        if (!s_last) begin
                            err_d = 1'b1;
                        end
                        w_loaded_d = 1'b1;
                        state_d    = FIRE;
                    end else if (s_last) begin
                        err_d      = 1'b1;
                        w_loaded_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            FIRE: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (attn_done) begin
                    y_we    = 1'b1;
                    k_d     = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (m_ready) begin
                    if (k_q == KW'(EMBED_DIM - 1)) begin
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            xonly_q    <= 1'b0;
            w_loaded_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < EMBED_DIM; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            for (int n = 0; n < NW; n++) begin
                w_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            xonly_q    <= xonly_d;
            w_loaded_q <= w_loaded_d;
            err_q      <= err_d;
            if (x_we) begin
                x_q[x_idx] <= s_data;
            end
            if (w_we) begin
                w_q[cnt_q] <= s_data;
            end
            if (y_we) begin
                for (int i = 0; i < EMBED_DIM; i++) begin
                    y_q[i] <= attn_y[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        x_flat  = '0;
        wq_flat = '0;
        wk_flat = '0;
        wv_flat = '0;
        wo_flat = '0;
        for (int i = 0; i < EMBED_DIM; i++) begin
            x_flat[i*DATA_WIDTH +: DATA_WIDTH] = x_q[i];
        end
        for (int e = 0; e < MSZ; e++) begin
            wq_flat[e*DATA_WIDTH +: DATA_WIDTH] = w_q[e];
            wk_flat[e*DATA_WIDTH +: DATA_WIDTH] = w_q[MSZ + e];
            wv_flat[e*DATA_WIDTH +: DATA_WIDTH] = w_q[2*MSZ + e];
            wo_flat[e*DATA_WIDTH +: DATA_WIDTH] = w_q[3*MSZ + e];
        end
    end

endmodule

// File: tb/tb_attn_stream_loader.sv
module tb_attn_stream_loader;

    localparam int ED  = 8;
    localparam int DW  = 16;
    localparam int MSZ = ED * ED;
    localparam int NW  = 4 * MSZ;
    localparam int NT  = ED + NW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_data;
    logic                 s_last;
    logic                 reuse_w;
    logic [ED*DW-1:0]     x_flat;
    logic [MSZ*DW-1:0]    wq_flat, wk_flat, wv_flat, wo_flat;
    logic                 attn_start;
    logic                 attn_done;
    logic [ED*DW-1:0]     attn_y;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_data;
    logic                 m_last;
    logic                 busy;
    logic                 err;

    int            errors    = 0;
    int            checks    = 0;
    int            start_cnt = 0;
    logic [15:0]   ybase     = 16'h1000;

    always #5 clk = ~clk;

    attn_stream_loader #(.EMBED_DIM(ED), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .reuse_w(reuse_w),
        .x_flat(x_flat), .wq_flat(wq_flat), .wk_flat(wk_flat), .wv_flat(wv_flat),
        .wo_flat(wo_flat),
        .attn_start(attn_start), .attn_done(attn_done), .attn_y(attn_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("%s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Weight stream value: Wq diagonal 0x0100, every other weight 0x0001.
    function automatic logic [15:0] exp_w(input int n);
        int mat, e;
        mat = n / MSZ;
        e   = n % MSZ;
        return (mat == 0 && (e / ED) == (e % ED)) ? 16'h0100 : 16'h0001;
    endfunction

    // Attention unit model: result words ybase+k, done three cycles after start.
    initial begin
        attn_done = 1'b0;
        attn_y    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (attn_start === 1'b1) begin
                start_cnt++;
                for (int k = 0; k < ED; k++) attn_y[k*DW +: DW] = ybase + 16'(k);
                repeat (3) @(posedge clk);
                #1 attn_done = 1'b1;
                @(posedge clk);
                #1 attn_done = 1'b0;
            end
        end
    end

    task automatic load(input int early_at, input bit reuse, input int nwords,
                        input logic [15:0] xbase, input bit expect_fire);
        for (int w = 0; w < nwords; w++) begin
            chk("s_ready_beat", s_ready, 1);
            s_valid = 1'b1;
            s_data  = (w < ED) ? xbase + 16'(w + 1) : exp_w(w - ED);
            s_last  = (w == nwords - 1) || (w == early_at);
            reuse_w = reuse;
            step();
            if (w == 0 && early_at != 0) chk("busy_after_first", busy, 1);
            if (w == early_at) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        reuse_w = 1'b0;
        if (expect_fire) begin
            chk("attn_start_pulse", attn_start, 1);
            chk("s_ready_drop", s_ready, 0);
            step();
            chk("attn_start_once", attn_start, 0);
            chk("busy_wait", busy, 1);
        end
    endtask

    task automatic check_bus(input logic [15:0] xbase);
        logic [15:0] word;
        for (int i = 0; i < ED; i++) chk("x_flat", x_flat[i*DW +: DW], xbase + 16'(i + 1));
        for (int n = 0; n < NW; n++) begin
            case (n / MSZ)
                0:       word = wq_flat[(n % MSZ)*DW +: DW];
                1:       word = wk_flat[(n % MSZ)*DW +: DW];
                2:       word = wv_flat[(n % MSZ)*DW +: DW];
                default: word = wo_flat[(n % MSZ)*DW +: DW];
            endcase
            chk("w_flat", word, exp_w(n));
        end
    endtask

    task automatic recv(input logic [15:0] base, input bit toggle);
        int cyc = 0;
        int k   = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("m_valid_rise", m_valid, 1);
        cyc = 0;
        while (k < ED && cyc < 40) begin
            m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            chk("m_valid_hold", m_valid, 1);
            chk("m_data", m_data, base + 16'(k));
            chk("m_last", m_last, (k == ED - 1));
            step();
            if (m_ready) k++;
            cyc++;
        end
        m_ready = 1'b0;
        chk("words_delivered", k, ED);
        chk("send_cycles", cyc, toggle ? 2 * ED - 1 : ED);
        chk("busy_after_send", busy, 0);
        chk("m_valid_after_send", m_valid, 0);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; reuse_w = 1'b0; m_ready = 1'b0;
        step();
        step();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_attn_start", attn_start, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_x_flat", |x_flat, 0);
        chk("rst_w_flat", |{wq_flat, wk_flat, wv_flat, wo_flat}, 0);
        chk("rst_w_loaded", dut.w_loaded_q, 0);
        rst = 1'b0;
        step();
        chk("idle_s_ready", s_ready, 1);
        chk("idle_busy", busy, 0);

        // Full load, then result streamed with m_ready held high.
        ybase = 16'h1000;
        load(-1, 1'b0, NT, 16'h0000, 1'b1);
        check_bus(16'h0000);
        chk("full_w_loaded", dut.w_loaded_q, 1);
        chk("full_err", err, 0);
        recv(16'h1000, 1'b0);
        chk("full_start_cnt", start_cnt, 1);

        // x-only reuse load, result streamed with m_ready toggling.
        ybase = 16'h2000;
        load(-1, 1'b1, ED, 16'h0A00, 1'b1);
        check_bus(16'h0A00);
        chk("reuse_err", err, 0);
        recv(16'h2000, 1'b1);
        chk("reuse_start_cnt", start_cnt, 2);

        // Early s_last on word 100 of a full load.
        load(100, 1'b0, NT, 16'h0000, 1'b0);
        chk("early_err", err, 1);
        chk("early_w_loaded", dut.w_loaded_q, 0);
        chk("early_busy", busy, 0);
        chk("early_s_ready", s_ready, 1);
        repeat (6) step();
        chk("early_no_start", start_cnt, 2);
        chk("early_no_output", m_valid, 0);

        // Reset in the middle of LOAD_W, then a clean full load.
        for (int w = 0; w < 50; w++) begin
            s_valid = 1'b1;
            s_data  = (w < ED) ? 16'(w + 1) : exp_w(w - ED);
            s_last  = 1'b0;
            step();
        end
        chk("midload_busy", busy, 1);
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_attn_start", attn_start, 0);
        chk("midrst_x_flat", |x_flat, 0);
        chk("midrst_w_flat", |{wq_flat, wk_flat, wv_flat, wo_flat}, 0);
        chk("midrst_w_loaded", dut.w_loaded_q, 0);
        rst = 1'b0;
        step();
        ybase = 16'h1000;
        load(-1, 1'b0, NT, 16'h0000, 1'b1);
        chk("after_rst_err", err, 0);
        recv(16'h1000, 1'b0);
        chk("after_rst_start_cnt", start_cnt, 3);

        // reuse_w straight after reset is treated as a full load and flagged.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        ybase = 16'h3000;
        load(-1, 1'b1, NT, 16'h0000, 1'b1);
        chk("noweights_err", err, 1);
        chk("noweights_w_loaded", dut.w_loaded_q, 1);
        check_bus(16'h0000);
        recv(16'h3000, 1'b0);
        chk("noweights_start_cnt", start_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
